fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Multi-cycle instruction fetch/execute sequencer for the accumulator CPU. Owns the program
//   counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake,
//   presents the held word to the control unit for one execute cycle, then advances or branches.
//   Halts on HLT (opcode 5'b00000) until reset.
// PARAMETERS
//   ADDRESS_WIDTH      11  program counter / instruction memory address width
//   INSTRUCTION_WIDTH  16  instruction word width; opcode = bits [15:11]
//   RESET_VECTOR        0  PC value loaded on reset
//   COUNT_WIDTH        16  width of retired-instruction counter
// PORTS
//   clock_in              in   1   system clock, rising edge
//   reset_in              in   1   synchronous, active-high reset
//   imem_req_out          out  1   fetch request to instruction memory
//   imem_addr_out         out  AW  fetch address (= PC)
//   imem_ack_in           in   1   memory ack; imem_data_in valid in the same cycle
//   imem_data_in          in   IW  fetched instruction word
//   instruction_out       out  IW  instruction register, to control.instruction_in
//   instruction_valid_out out  1   high during the EXECUTE cycle(s)
//   stall_in              in   1   control requests EXECUTE be held another cycle
//   branch_in             in   1   branch/jump taken, sampled on final EXECUTE cycle
//   branch_target_in      in   AW  branch target (control address_out)
//   pc_out                out  AW  current PC
//   halted_out            out  1   high in HALT state
//   retired_count_out     out  CW  number of completed instructions, saturating
// BEHAVIOUR
//   - States: FETCH, EXECUTE, HALT. All state, PC, IR, counter are registers; outputs decoded
//     from registers only (no combinational in->out paths).
//   - Reset (reset_in high at rising edge): state=FETCH, PC=RESET_VECTOR, IR=0,
//     retired_count=0. imem_req_out is forced 0 while reset_in is high; instruction_valid_out=0,
//     halted_out=0. Reset wins over every other input, in every state, incl. mid-handshake.
//   - FETCH: imem_req_out=1, imem_addr_out=PC, both held stable until ack. On a cycle with
//     req=1 and imem_ack_in=1: IR<=imem_data_in, next state EXECUTE. Minimum fetch = 1 cycle
//     (ack in first req cycle). Ack while req=0 or in any other state is ignored.
//   - EXECUTE: imem_req_out=0, instruction_valid_out=1, instruction_out=IR (stable).
//     * stall_in=1: remain in EXECUTE, PC/IR unchanged, branch_in ignored.
//     * stall_in=0, IR[15:11]==5'b00000 (HLT): next HALT, PC unchanged, count not incremented.
//     * stall_in=0, branch_in=1: PC<=branch_target_in, next FETCH, count+1.
//     * stall_in=0, branch_in=0: PC<=PC+1 modulo 2^AW (0x7FF -> 0x000), next FETCH, count+1.
//   - HALT: req=0, valid=0, halted_out=1; all inputs except reset_in ignored; exit only by reset.
//   - retired_count saturates at 2^CW-1 (no wrap).
//   - Instruction throughput without wait/stall: one instruction per 2 cycles.
// TESTING
//   1 reset 3 cycles, release -> first cycle after: req=1, addr=0x000, valid=0, halted=0, count=0.
//   2 ack after 3 req cycles with data 0x1801 (LDI 1) -> addr held 0x000 for 3 cycles, IR=0x1801,
//     valid=1 next cycle, then req=1 addr=0x001, count=1.
//   3 EXECUTE of 0x7000 (JMP) with branch_in=1 target 0x155, stall_in=1 for 2 cycles then 0
//     -> valid high 3 cycles, next fetch addr=0x155, count incremented once.
//   4 PC=0x7FF, non-branch instruction executes -> next fetch addr=0x000.
//   5 fetch 0x0000 (HLT) -> halted=1, req=0 for 20 cycles despite ack/branch toggling; reset
//     -> req=1 addr=RESET_VECTOR.
//   6 reset asserted during FETCH wait (req=1, no ack) with ack arriving in reset cycle
//     -> IR stays 0, req=0 while reset high, PC=0 after release, no EXECUTE entered.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle instruction fetch/execute sequencer for the accumulator CPU.
//   Owns the program counter, fetches instruction words over a req/ack
//   handshake, presents the held word to control for the EXECUTE cycle(s),
//   then advances or branches. HLT (opcode 5'b00000) parks the sequencer in
//   HALT until reset.
//
// Ports
//   clock_in              system clock, rising edge
//   reset_in              synchronous, active-high reset
//   imem_req_out          fetch request (held with address until ack)
//   imem_addr_out         fetch address (= PC)
//   imem_ack_in           memory ack; imem_data_in valid in the same cycle
//   imem_data_in          fetched instruction word
//   instruction_out       instruction register
//   instruction_valid_out high during EXECUTE
//   stall_in              hold EXECUTE another cycle
//   branch_in             branch taken, sampled on final EXECUTE cycle
//   branch_target_in      branch target address
//   pc_out                current PC
//   halted_out            high in HALT
//   retired_count_out     completed instructions, saturating
module fetch_sequencer #(
  parameter int unsigned ADDRESS_WIDTH     = 11,
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  output logic                         imem_req_out,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr_out,
  input  logic                         imem_ack_in,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         instruction_valid_out,
  input  logic                         stall_in,
  input  logic                         branch_in,
  input  logic [ADDRESS_WIDTH-1:0]     branch_target_in,
  output logic [ADDRESS_WIDTH-1:0]     pc_out,
  output logic                         halted_out,
  output logic [COUNT_WIDTH-1:0]       retired_count_out
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [4:0] OPCODE_HLT = 5'b00000;

  state_t                         state, state_next;
  logic [ADDRESS_WIDTH-1:0]       pc, pc_next;
  logic [INSTRUCTION_WIDTH-1:0]   ir, ir_next;
  logic [COUNT_WIDTH-1:0]         count, count_next;
  logic [COUNT_WIDTH-1:0]         count_inc;
  logic                           is_hlt;

  assign is_hlt    = (ir[INSTRUCTION_WIDTH-1 -: 5] == OPCODE_HLT);
  assign count_inc = (count == '1) ? count : count + 1'b1;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= FETCH;
      pc    <= RESET_VECTOR;
      ir    <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    count_next = count;
    unique case (state)
      FETCH: begin
        if (imem_ack_in) begin
          ir_next    = imem_data_in;
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        if (!stall_in) begin
          if (is_hlt) begin
            state_next = HALT;
          end else begin
            pc_next    = branch_in ? branch_target_in : pc + 1'b1;
            count_next = count_inc;
            state_next = FETCH;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Status outputs come from registers; reset_in only masks them so nothing
  // is requested or reported while reset is being held.
  assign imem_req_out          = (state == FETCH)   && !reset_in;
  assign instruction_valid_out = (state == EXECUTE) && !reset_in;
  assign halted_out            = (state == HALT)    && !reset_in;
  assign imem_addr_out         = pc;
  assign pc_out                = pc;
  assign instruction_out       = ir;
  assign retired_count_out     = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int unsigned AW = 11;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [IW-1:0] data_in;
  logic [IW-1:0] instr;
  logic          valid;
  logic          stall;
  logic          branch;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          halted;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDRESS_WIDTH    (AW),
    .INSTRUCTION_WIDTH(IW),
    .RESET_VECTOR     (11'h000),
    .COUNT_WIDTH      (CW)
  ) dut (
    .clock_in             (clk),
    .reset_in             (rst),
    .imem_req_out         (req),
    .imem_addr_out        (addr),
    .imem_ack_in          (ack),
    .imem_data_in         (data_in),
    .instruction_out      (instr),
    .instruction_valid_out(valid),
    .stall_in             (stall),
    .branch_in            (branch),
    .branch_target_in     (target),
    .pc_out               (pc),
    .halted_out           (halted),
    .retired_count_out    (count)
  );

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [IW-1:0] sb_q[$];
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_count;
  logic [IW-1:0] m_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    ack = 1'b1;
    #1;
    check("rst_req", req, 0);
    for (int unsigned i = 0; i < cycles; i++) begin
      tick;
      check("rst_req", req, 0);
      check("rst_valid", valid, 0);
      check("rst_halted", halted, 0);
    end
    rst = 1'b0;
    ack = 1'b0;
    m_pc = '0; m_count = '0; m_ir = '0;
    #1;
    check("post_rst_req", req, 1);
    check("post_rst_addr", addr, 32'(m_pc));
    check("post_rst_valid", valid, 0);
    check("post_rst_halted", halted, 0);
    check("post_rst_count", count, 0);
    check("post_rst_ir", instr, 0);
  endtask

  // Holds the request for 'waits' cycles without ack, then acks with 'data'.
  task automatic do_fetch(input int unsigned waits, input logic [IW-1:0] data);
    logic [IW-1:0] exp;
    for (int unsigned i = 0; i < waits; i++) begin
      ack = 1'b0;
      data_in = IW'($urandom);
      check("fetch_req", req, 1);
      check("fetch_addr", addr, 32'(m_pc));
      check("fetch_valid", valid, 0);
      tick;
    end
    check("fetch_req", req, 1);
    check("fetch_addr", addr, 32'(m_pc));
    ack = 1'b1;
    data_in = data;
    sb_q.push_back(data);
    m_ir = data;
    tick;
    ack = 1'b0;
    data_in = IW'($urandom);
    check("exec_valid", valid, 1);
    check("exec_req", req, 0);
    check("sb_size", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check("exec_ir", instr, 32'(exp));
    end
  endtask

  // Stalls 'stalls' cycles (with a misleading branch offered), then completes.
  task automatic do_exec(input int unsigned stalls, input logic br, input logic [AW-1:0] tgt);
    for (int unsigned i = 0; i < stalls; i++) begin
      stall = 1'b1;
      branch = 1'b1;
      target = ~tgt;
      tick;
      check("stall_valid", valid, 1);
      check("stall_ir", instr, 32'(m_ir));
      check("stall_pc", pc, 32'(m_pc));
      check("stall_req", req, 0);
    end
    stall = 1'b0;
    branch = br;
    target = tgt;
    tick;
    branch = 1'b0;
    if (m_ir[15:11] == 5'b00000) begin
      check("hlt_halted", halted, 1);
      check("hlt_req", req, 0);
      check("hlt_valid", valid, 0);
      check("hlt_pc", pc, 32'(m_pc));
      check("hlt_count", count, 32'(m_count));
    end else begin
      m_pc = br ? tgt : m_pc + 1'b1;
      if (m_count != '1) m_count = m_count + 1'b1;
      check("next_req", req, 1);
      check("next_addr", addr, 32'(m_pc));
      check("next_valid", valid, 0);
      check("next_count", count, 32'(m_count));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0]    op;
    logic [IW-1:0] word;
    logic          br;
    logic [AW-1:0] tgt;
    rst = 1'b0; ack = 1'b0; data_in = '0; stall = 1'b0; branch = 1'b0; target = '0;
    m_pc = '0; m_count = '0; m_ir = '0;
    #2;

    // 1: reset 3 cycles
    do_reset(3);

    // 2: LDI 1 acked after 3 waiting request cycles
    do_fetch(3, 16'h1801);
    do_exec(0, 1'b0, '0);

    // 3: JMP with 2 stall cycles
    do_fetch(0, 16'h7000);
    do_exec(2, 1'b1, 11'h155);

    // 4: PC wraps 0x7FF -> 0x000
    do_fetch(0, 16'h7000);
    do_exec(0, 1'b1, 11'h7FF);
    do_fetch(1, 16'h1801);
    do_exec(0, 1'b0, '0);

    // Mixed non-HLT traffic; also drives the 4-bit counter into saturation.
    for (int unsigned i = 0; i < 20; i++) begin
      op   = 5'($urandom_range(1, 31));
      word = {op, 11'($urandom)};
      br   = 1'($urandom);
      tgt  = AW'($urandom);
      do_fetch($urandom_range(0, 2), word);
      do_exec($urandom_range(0, 2), br, tgt);
    end
    check("count_saturated", count, 32'((1 << CW) - 1));

    // 5: HLT, inputs ignored for 20 cycles, reset recovers
    do_fetch(0, 16'h0000);
    do_exec(0, 1'b1, 11'h2AA);
    for (int unsigned i = 0; i < 20; i++) begin
      ack = 1'($urandom);
      branch = 1'($urandom);
      stall = 1'($urandom);
      target = AW'($urandom);
      data_in = IW'($urandom);
      tick;
      check("halt_halted", halted, 1);
      check("halt_req", req, 0);
      check("halt_valid", valid, 0);
      check("halt_pc", pc, 32'(m_pc));
      check("halt_count", count, 32'(m_count));
    end
    ack = 1'b0; branch = 1'b0; stall = 1'b0;
    do_reset(1);

    // 6: reset during a fetch wait, with ack arriving in the reset cycle
    do_fetch(0, 16'h1801);
    do_exec(0, 1'b0, '0);
    ack = 1'b0;
    tick;
    check("wait_req", req, 1);
    check("wait_addr", addr, 32'(m_pc));
    rst = 1'b1;
    ack = 1'b1;
    data_in = 16'h1234;
    #1;
    check("midrst_req", req, 0);
    tick;
    rst = 1'b0;
    ack = 1'b0;
    m_pc = '0; m_count = '0; m_ir = '0;
    #1;
    check("midrst_ir", instr, 0);
    check("midrst_pc", pc, 0);
    check("midrst_req", req, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick;
      check("midrst_no_exec", valid, 0);
      check("midrst_ir_hold", instr, 0);
      check("midrst_addr", addr, 0);
    end
    do_fetch(0, 16'h2003);
    do_exec(1, 1'b0, '0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
